// File: rtl/poly_basemul_ctrl_pkg.sv
// Shared constants, FSM encoding and modular-add helper for the Kyber basemul sequencer.
package poly_basemul_ctrl_pkg;

  localparam int unsigned KYBER_Q       = 3329;
  localparam int unsigned KYBER_N_PAIRS = 128;
  localparam int unsigned PAIR_ADDR_W   = 7;
  localparam int unsigned COEF_W        = 12;
  localparam int unsigned WORD_W        = 2 * COEF_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Add two residues in [0,q-1] and fold the sum back into [0,q-1].
  function automatic logic [COEF_W-1:0] mod_add(input logic [COEF_W-1:0] x,
                                                input logic [COEF_W-1:0] y);
    logic [COEF_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= (COEF_W+1)'(KYBER_Q)) s = s - (COEF_W+1)'(KYBER_Q);
    return s[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/poly_basemul_ctrl_basemul_unit.sv
// Combinational Kyber base multiplication of one degree-1 pair modulo (X^2 - gamma).
module basemul_unit
  import poly_basemul_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [COEF_W-1:0] g,
  output logic [WORD_W-1:0] c
);

  localparam int unsigned PROD_W = 2 * COEF_W;

  logic [PROD_W-1:0] p00, p11, p01, p10, pg;
  logic [COEF_W-1:0] r00, r11, r01, r10, rg;

  // c0 = a0*b0 + g*a1*b1, c1 = a0*b1 + a1*b0, each reduced mod q.
  always_comb begin
    p00 = PROD_W'(a[COEF_W-1:0])      * PROD_W'(b[COEF_W-1:0]);
    p11 = PROD_W'(a[WORD_W-1:COEF_W]) * PROD_W'(b[WORD_W-1:COEF_W]);
    p01 = PROD_W'(a[COEF_W-1:0])      * PROD_W'(b[WORD_W-1:COEF_W]);
    p10 = PROD_W'(a[WORD_W-1:COEF_W]) * PROD_W'(b[COEF_W-1:0]);
    r00 = COEF_W'(p00 % PROD_W'(KYBER_Q));
    r11 = COEF_W'(p11 % PROD_W'(KYBER_Q));
    r01 = COEF_W'(p01 % PROD_W'(KYBER_Q));
    r10 = COEF_W'(p10 % PROD_W'(KYBER_Q));
    pg  = PROD_W'(g) * PROD_W'(r11);
    rg  = COEF_W'(pg % PROD_W'(KYBER_Q));
    c   = {mod_add(r01, r10), mod_add(r00, rg)};
  end

endmodule

// File: rtl/poly_basemul_ctrl.sv
// Streams 128 coefficient pairs through basemul_unit, optionally accumulating into C.
module poly_basemul_ctrl
  import poly_basemul_ctrl_pkg::*;
#(
  parameter int unsigned N_PAIRS = KYBER_N_PAIRS,
  parameter int unsigned ADDR_W  = PAIR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              acc_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [23:0]       a_rdata,
  input  logic [23:0]       b_rdata,
  input  logic [11:0]       g_rdata,
  input  logic [23:0]       c_rdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(N_PAIRS - 1);

  state_t            state;
  logic [ADDR_W-1:0] k;
  logic              acc_q;
  logic              drain_cnt;
  logic              v1;
  logic [ADDR_W-1:0] addr1;
  logic [23:0]       bm_c;
  logic [23:0]       res;

  // Control FSM: issues one read per cycle in RUN, then waits for the pipeline to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      k         <= '0;
      acc_q     <= 1'b0;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc_q   <= acc_en;
            k       <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (k == LAST_K) begin
            rd_en     <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            k       <= k + ADDR_W'(1);
            rd_addr <= k + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: valid/address of the read whose data is on the rdata buses this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      addr1 <= '0;
    end else begin
      v1    <= rd_en;
      addr1 <= rd_addr;
    end
  end

  basemul_unit u_basemul (
    .a (a_rdata),
    .b (b_rdata),
    .g (g_rdata),
    .c (bm_c)
  );

  // Optional modular accumulation with the existing C pair.
  always_comb begin
    res = bm_c;
    if (acc_q) begin
      res = {mod_add(bm_c[23:12], c_rdata[23:12]), mod_add(bm_c[11:0], c_rdata[11:0])};
    end
  end

  // Stage 2: registered result write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= v1;
      if (v1) begin
        wr_addr <= addr1;
        wr_data <= res;
      end
    end
  end

endmodule

// File: tb/tb_poly_basemul_ctrl.sv
// Directed bench for poly_basemul_ctrl with synchronous memory models and a reference model.
module tb_poly_basemul_ctrl;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        acc_en;
  logic        busy;
  logic        done;
  logic [6:0]  rd_addr;
  logic        rd_en;
  logic [23:0] a_rdata;
  logic [23:0] b_rdata;
  logic [11:0] g_rdata;
  logic [23:0] c_rdata;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [23:0] wr_data;

  logic [23:0] mem_a [128];
  logic [23:0] mem_b [128];
  logic [23:0] mem_c [128];
  logic [11:0] mem_g [128];
  logic [23:0] res   [128];

  int total = 0;
  int bad   = 0;

  poly_basemul_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .acc_en  (acc_en),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_en   (rd_en),
    .a_rdata (a_rdata),
    .b_rdata (b_rdata),
    .g_rdata (g_rdata),
    .c_rdata (c_rdata),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  // Synchronous read memories: data one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= mem_a[rd_addr];
      b_rdata <= mem_b[rd_addr];
      g_rdata <= mem_g[rd_addr];
      c_rdata <= mem_c[rd_addr];
    end
  end

  // Result memory capture.
  always @(posedge clk) begin
    if (wr_en) res[wr_addr] <= wr_data;
  end

  function automatic logic [23:0] pk(input int hi, input int lo);
    return {12'(hi), 12'(lo)};
  endfunction

  function automatic logic [23:0] ref_pair(input int idx, input logic acc);
    longint a0, a1, b0, b1, g, c0, c1;
    a0 = longint'(mem_a[idx][11:0]);  a1 = longint'(mem_a[idx][23:12]);
    b0 = longint'(mem_b[idx][11:0]);  b1 = longint'(mem_b[idx][23:12]);
    g  = longint'(mem_g[idx]);
    c0 = (a0 * b0 + g * ((a1 * b1) % Q)) % Q;
    c1 = (a0 * b1 + a1 * b0) % Q;
    if (acc) begin
      c0 = (c0 + longint'(mem_c[idx][11:0]))  % Q;
      c1 = (c1 + longint'(mem_c[idx][23:12])) % Q;
    end
    return {12'(c1), 12'(c0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
  endtask

  // Entered at #1 inside an idle cycle T; start is sampled at the end of T.
  task automatic do_run(input logic acc, input logic inject, input int abort_at);
    start  = 1'b1;
    acc_en = acc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 131; c++) begin
      if (c == abort_at) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        return;
      end
      chk("rd_en", 32'(rd_en), 32'(c <= 128));
      if (c <= 128) chk("rd_addr", 32'(rd_addr), 32'(c - 1));
      chk("busy",  32'(busy),  32'(c <= 130));
      chk("done",  32'(done),  32'(c == 131));
      chk("wr_en", 32'(wr_en), 32'(c >= 3 && c <= 130));
      if (c >= 3 && c <= 130) begin
        chk("wr_addr", 32'(wr_addr), 32'(c - 3));
        chk("wr_data", 32'(wr_data), 32'(ref_pair(c - 3, acc)));
      end
      start = inject && (c == 50 || c == 131);
      if (c == 20) acc_en = ~acc;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk_idle("post_run");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; acc_en = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem_a[i] = pk($urandom_range(3328, 0), $urandom_range(3328, 0));
      mem_b[i] = pk($urandom_range(3328, 0), $urandom_range(3328, 0));
      mem_c[i] = pk($urandom_range(3328, 0), $urandom_range(3328, 0));
      mem_g[i] = 12'($urandom_range(3328, 0));
    end
    mem_a[0] = pk(0, 1);       mem_b[0] = pk(7, 5);       mem_g[0] = 12'd17;
    mem_a[1] = pk(1, 0);       mem_b[1] = pk(1, 0);       mem_g[1] = 12'd17;
    mem_a[2] = pk(1, 0);       mem_b[2] = pk(1, 0);       mem_g[2] = 12'd3312;
    mem_a[3] = pk(3328, 3328); mem_b[3] = pk(3328, 3328); mem_g[3] = 12'd3328;
    mem_c[3] = pk(3328, 3328);

    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Run 1: plain multiply, stray start pulses in RUN and DONE.
    do_run(1'b0, 1'b1, 0);
    chk("vec_k0_7_5",    32'(res[0]), 32'h007005);
    chk("vec_k1_g17",    32'(res[1]), 32'h000011);
    chk("vec_k2_g3312",  32'(res[2]), 32'h000CF0);
    chk("vec_k3_max",    32'(res[3]), 32'h002000);

    // Run 2 starts at T+132 of run 1: accumulate mode, acc_en toggled mid-run.
    for (int i = 4; i < 128; i++) mem_c[i] = pk($urandom_range(3328, 0), $urandom_range(3328, 0));
    do_run(1'b1, 1'b0, 0);
    chk("vec_k3_max_acc", 32'(res[3]), 32'h001D00);

    // Run 3: reset while rd_addr=60 is being issued.
    @(posedge clk); #1;
    do_run(1'b0, 1'b0, 61);
    @(posedge clk); #1;
    chk_idle("in_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_idle("after_rst");
    end

    // Run 4: full sequence after reset release.
    for (int i = 0; i < 128; i++) res[i] = 24'hFFFFFF;
    do_run(1'b0, 1'b0, 0);
    for (int i = 0; i < 128; i++) chk("rerun_res", 32'(res[i]), 32'(ref_pair(i, 1'b0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
